// File: rtl/pc_sequencer.sv
// pc_sequencer: program-counter sequencer with stride increment, stall,
// PC-relative branch, absolute jump, and call/return through a circular
// return-address stack (RAS).
// Optional feature macro: PC_ALIGN_CHECK_EN. When defined, jump, call and
// branch results that are not a multiple of STRIDE are rejected. A rejected
// redirect falls through to pc_plus and pulses misalign.
module pc_sequencer #(
    parameter int                 WIDTH        = 32,
    parameter int                 DEPTH        = 4,
    parameter logic [WIDTH-1:0]   RESET_VECTOR = '0,
    parameter int                 STRIDE       = 4
) (
    input  logic                        clock,
    input  logic                        reset,
    input  logic                        stall,
    input  logic                        branch_en,
    input  logic [WIDTH-1:0]            branch_off,
    input  logic                        jump_en,
    input  logic                        call_en,
    input  logic                        ret_en,
    input  logic [WIDTH-1:0]            target,
    output logic [WIDTH-1:0]            pc,
    output logic [WIDTH-1:0]            pc_plus,
    output logic [$clog2(DEPTH):0]      ras_count,
    output logic                        ras_ovf,
    output logic                        ras_unf,
    output logic                        misalign
);

    localparam int               PW       = $clog2(DEPTH);
    localparam int               CW       = PW + 1;
    localparam logic [WIDTH-1:0] STRIDE_W = WIDTH'(STRIDE);
    localparam logic [CW-1:0]    FULL_CNT = CW'(DEPTH);

    // Architectural state
    logic [WIDTH-1:0] pc_q, pc_d;
    logic [PW-1:0]    ptr_q, ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             ovf_q, ovf_d;
    logic             unf_q, unf_d;
    logic             mis_q, mis_d;
    logic [WIDTH-1:0] ras_q [DEPTH];

    // Datapath helpers
    logic [WIDTH-1:0] pc_plus_s;
    logic [WIDTH-1:0] branch_addr_s;
    logic [WIDTH-1:0] top_s;
    logic             push_s;
    logic             call_bad_s;
    logic             jump_bad_s;
    logic             branch_bad_s;

    assign pc_plus_s     = pc_q + STRIDE_W;
    assign branch_addr_s = pc_q + branch_off;
    // Top of stack sits one slot below the write pointer (wraps modulo DEPTH).
    assign top_s         = ras_q[ptr_q - PW'(1)];

`ifdef PC_ALIGN_CHECK_EN
    // True when the address is not a whole multiple of the stride.
    function automatic logic is_misaligned(input logic [WIDTH-1:0] addr);
        return (addr % STRIDE_W) != {WIDTH{1'b0}};
    endfunction

    assign call_bad_s   = is_misaligned(target);
    assign jump_bad_s   = is_misaligned(target);
    assign branch_bad_s = is_misaligned(branch_addr_s);
`else
    assign call_bad_s   = 1'b0;
    assign jump_bad_s   = 1'b0;
    assign branch_bad_s = 1'b0;
`endif

    // Next-state selection in strict priority: stall, ret, call, jump, branch, sequential.
    always_comb begin
        pc_d    = pc_q;
        ptr_d   = ptr_q;
        count_d = count_q;
        ovf_d   = ovf_q;
        unf_d   = 1'b0;
        mis_d   = 1'b0;
        push_s  = 1'b0;
        if (stall) begin
            pc_d = pc_q;
        end else if (ret_en) begin
            if (count_q == {CW{1'b0}}) begin
                pc_d  = pc_plus_s;
                unf_d = 1'b1;
            end else begin
                pc_d    = top_s;
                ptr_d   = ptr_q - PW'(1);
                count_d = count_q - CW'(1);
            end
        end else if (call_en) begin
            if (call_bad_s) begin
                pc_d  = pc_plus_s;
                mis_d = 1'b1;
            end else begin
                pc_d   = target;
                push_s = 1'b1;
                ptr_d  = ptr_q + PW'(1);
                if (count_q == FULL_CNT) begin
                    ovf_d = 1'b1;
                end else begin
                    count_d = count_q + CW'(1);
                end
            end
        end else if (jump_en) begin
            if (jump_bad_s) begin
                pc_d  = pc_plus_s;
                mis_d = 1'b1;
            end else begin
                pc_d = target;
            end
        end else if (branch_en) begin
            if (branch_bad_s) begin
                pc_d  = pc_plus_s;
                mis_d = 1'b1;
            end else begin
                pc_d = branch_addr_s;
            end
        end else begin
            pc_d = pc_plus_s;
        end
    end

    // Control state registers with asynchronous reset.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            pc_q    <= RESET_VECTOR;
            ptr_q   <= {PW{1'b0}};
            count_q <= {CW{1'b0}};
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
            mis_q   <= 1'b0;
        end else begin
            pc_q    <= pc_d;
            ptr_q   <= ptr_d;
            count_q <= count_d;
            ovf_q   <= ovf_d;
            unf_q   <= unf_d;
            mis_q   <= mis_d;
        end
    end

    // RAS storage: data survives reset, only the pointer and count are cleared.
    always_ff @(posedge clock) begin
        if (push_s) begin
            ras_q[ptr_q] <= pc_plus_s;
        end else begin
            ras_q[ptr_q] <= ras_q[ptr_q];
        end
    end

    assign pc        = pc_q;
    assign pc_plus   = pc_plus_s;
    assign ras_count = count_q;
    assign ras_ovf   = ovf_q;
    assign ras_unf   = unf_q;
    assign misalign  = mis_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed testbench for pc_sequencer with default parameters.
module tb_pc_sequencer;

    logic        clock;
    logic        reset;
    logic        stall;
    logic        branch_en;
    logic [31:0] branch_off;
    logic        jump_en;
    logic        call_en;
    logic        ret_en;
    logic [31:0] target;
    logic [31:0] pc;
    logic [31:0] pc_plus;
    logic [2:0]  ras_count;
    logic        ras_ovf;
    logic        ras_unf;
    logic        misalign;

    int checks   = 0;
    int failures = 0;

    pc_sequencer dut (
        .clock      (clock),
        .reset      (reset),
        .stall      (stall),
        .branch_en  (branch_en),
        .branch_off (branch_off),
        .jump_en    (jump_en),
        .call_en    (call_en),
        .ret_en     (ret_en),
        .target     (target),
        .pc         (pc),
        .pc_plus    (pc_plus),
        .ras_count  (ras_count),
        .ras_ovf    (ras_ovf),
        .ras_unf    (ras_unf),
        .misalign   (misalign)
    );

    // Free-running clock, 10 ns period.
    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Set controls, then advance one rising edge and settle 1 ns past it.
    task automatic step(input logic st, input logic br, input logic [31:0] off,
                        input logic jp, input logic cl, input logic rt,
                        input logic [31:0] tgt);
        stall      = st;
        branch_en  = br;
        branch_off = off;
        jump_en    = jp;
        call_en    = cl;
        ret_en     = rt;
        target     = tgt;
        @(posedge clock);
        #1;
    endtask

    task automatic idle();
        step(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0);
    endtask

    task automatic do_call(input logic [31:0] tgt);
        step(1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 1'b0, tgt);
    endtask

    task automatic do_ret();
        step(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 32'h0);
    endtask

    task automatic do_jump(input logic [31:0] tgt);
        step(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 1'b0, tgt);
    endtask

    initial begin
        reset = 1'b1; stall = 1'b0; branch_en = 1'b0; branch_off = 32'h0;
        jump_en = 1'b0; call_en = 1'b0; ret_en = 1'b0; target = 32'h0;
        #12;
        check_eq("rst_pc",    pc,                 32'h0);
        check_eq("rst_count", {29'h0, ras_count}, 32'h0);
        check_eq("rst_ovf",   {31'h0, ras_ovf},   32'h0);
        check_eq("rst_unf",   {31'h0, ras_unf},   32'h0);
        check_eq("rst_mis",   {31'h0, misalign},  32'h0);
        reset = 1'b0;

        // Free running
        idle(); check_eq("seq_4", pc, 32'h4);
        idle(); check_eq("seq_8", pc, 32'h8);
        idle(); check_eq("seq_c", pc, 32'hC);
        check_eq("seq_cnt", {29'h0, ras_count}, 32'h0);
        idle(); check_eq("seq_10", pc, 32'h10);
        check_eq("pc_plus_14", pc_plus, 32'h14);

        // Stall twice, then backward branch
        step(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0); check_eq("stall1", pc, 32'h10);
        step(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0); check_eq("stall2", pc, 32'h10);
        step(1'b0, 1'b1, 32'hFFFF_FFF8, 1'b0, 1'b0, 1'b0, 32'h0); check_eq("branch_back", pc, 32'h08);

        // Nested call / return
        do_jump(32'h20);      check_eq("jump_20", pc, 32'h20);
        do_call(32'h100);     check_eq("call1_pc", pc, 32'h100); check_eq("call1_cnt", {29'h0, ras_count}, 32'h1);
        do_call(32'h200);     check_eq("call2_pc", pc, 32'h200); check_eq("call2_cnt", {29'h0, ras_count}, 32'h2);
        do_ret();             check_eq("ret1_pc",  pc, 32'h104); check_eq("ret1_cnt",  {29'h0, ras_count}, 32'h1);
        do_ret();             check_eq("ret2_pc",  pc, 32'h24);  check_eq("ret2_cnt",  {29'h0, ras_count}, 32'h0);

        // Priority: ret beats call and jump, no push
        do_call(32'h300);     check_eq("call3_pc", pc, 32'h300);
        step(1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 1'b1, 32'h500);
        check_eq("prio_pc",  pc, 32'h28);
        check_eq("prio_cnt", {29'h0, ras_count}, 32'h0);
        check_eq("prio_unf", {31'h0, ras_unf},   32'h0);

        // Underflow pulse
        do_ret();  check_eq("unf_pc", pc, 32'h2C); check_eq("unf_hi", {31'h0, ras_unf}, 32'h1);
        idle();    check_eq("unf_lo", {31'h0, ras_unf}, 32'h0); check_eq("unf_next", pc, 32'h30);

        // Overflow: five calls into a four-deep stack
        do_call(32'h1000);
        do_call(32'h2000);
        do_call(32'h3000);
        do_call(32'h4000);
        check_eq("ovf_cnt4", {29'h0, ras_count}, 32'h4);
        check_eq("ovf_pre",  {31'h0, ras_ovf},   32'h0);
        do_call(32'h5000);
        check_eq("ovf_pc",   pc, 32'h5000);
        check_eq("ovf_cnt",  {29'h0, ras_count}, 32'h4);
        check_eq("ovf_set",  {31'h0, ras_ovf},   32'h1);
        do_ret(); check_eq("pop1", pc, 32'h4004); check_eq("pop1_cnt", {29'h0, ras_count}, 32'h3);
        do_ret(); check_eq("pop2", pc, 32'h3004);
        do_ret(); check_eq("pop3", pc, 32'h2004);
        do_ret(); check_eq("pop4", pc, 32'h1004); check_eq("pop4_cnt", {29'h0, ras_count}, 32'h0);
        do_ret(); check_eq("pop5", pc, 32'h1008); check_eq("pop5_unf", {31'h0, ras_unf}, 32'h1);
        check_eq("ovf_sticky", {31'h0, ras_ovf}, 32'h1);

        // Modulo wrap-around
        do_jump(32'hFFFF_FFFC);
        check_eq("wrap_plus", pc_plus, 32'h0);
        idle(); check_eq("wrap_pc", pc, 32'h0);

        // Alignment check
        do_jump(32'h40); check_eq("jump_40", pc, 32'h40);
        do_jump(32'h102);
`ifdef PC_ALIGN_CHECK_EN
        check_eq("mis_pc", pc, 32'h44);
        check_eq("mis_hi", {31'h0, misalign}, 32'h1);
`else
        check_eq("mis_pc", pc, 32'h102);
        check_eq("mis_hi", {31'h0, misalign}, 32'h0);
`endif
        idle(); check_eq("mis_lo", {31'h0, misalign}, 32'h0);

        // Asynchronous reset mid-sequence
        #2 reset = 1'b1;
        #1;
        check_eq("arst_pc",  pc, 32'h0);
        check_eq("arst_cnt", {29'h0, ras_count}, 32'h0);
        check_eq("arst_ovf", {31'h0, ras_ovf},   32'h0);
        @(negedge clock);
        reset = 1'b0;
        idle(); check_eq("arst_first", pc, 32'h4);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
